// File: rtl/ctrl_hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller: stage indices,
// operand-forwarding encodings, the stall FSM state type and address width.
package ctrl_hazard_pkg;

  localparam int REG_AW_DEF = 5;

  // Pipeline stage indices into the per-stage st_* buses
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int STG_RET = 3;

  // Number of stages that can still produce a hazard (RET never does)
  localparam int N_HAZ_STG = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Youngest matching stage wins the operand bypass
  function automatic fwd_e youngest_fwd(input logic [N_HAZ_STG-1:0] m);
    if (m[STG_EX])       return FWD_EX;
    else if (m[STG_MEM]) return FWD_MEM;
    else if (m[STG_WB])  return FWD_WB;
    else                 return FWD_RF;
  endfunction

  // Extra stall cycles beyond the first when the youngest producer is at stage k: 2 - k
  function automatic logic [1:0] extra_cycles(input logic [N_HAZ_STG-1:0] m);
    if (m[STG_EX])       return 2'd2;
    else if (m[STG_MEM]) return 2'd1;
    else                 return 2'd0;
  endfunction

endpackage

// File: rtl/ctrl_hazard_match.sv
// hazard_match: compares one decode source address against the destination
// of the EX, MEM and WB stages. Register 0 is hard-wired and never matches.
module hazard_match
  import ctrl_hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0]           i_rs,
  input  logic                        i_use,
  input  logic [N_HAZ_STG-1:0]        i_wen,
  input  logic [N_HAZ_STG*REG_AW-1:0] i_rd,
  output logic [N_HAZ_STG-1:0]        o_match
);

  // Per-stage address compare, qualified by write enable and source use
  always_comb begin
    o_match = '0;
    for (int i = 0; i < N_HAZ_STG; i++) begin
      o_match[i] = i_wen[i] & i_use & (i_rd[i*REG_AW +: REG_AW] == i_rs) & (i_rs != '0);
    end
  end

endmodule

// File: rtl/ctrl_hazard.sv
// ctrl_hazard: decode-stage RAW hazard detection, operand forwarding select
// and stall sequencing, with a saturating stalled-cycle counter.
// Build option: define CTRL_HAZARD_FWD_EN to enable EX/MEM/WB bypassing; then
// only a load in EX stalls (one cycle). Without it every in-flight producer
// stalls decode until it has written back (3 - k cycles for youngest stage k).
module ctrl_hazard
  import ctrl_hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use1,
  input  logic                id_use2,
  input  logic [3:0]          st_wen,
  input  logic [3:0]          st_load,
  input  logic [4*REG_AW-1:0] st_rd,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd1,
  output logic [1:0]          fwd2,
  output logic [CNT_W-1:0]    stall_cycles
);

  logic [N_HAZ_STG-1:0] w_m1;
  logic [N_HAZ_STG-1:0] w_m2;
  logic                 w_hazard_cond;
  logic                 w_hazard_now;
  logic [1:0]           w_extra;
  state_e               r_state;
  state_e               w_state_nxt;
  logic [1:0]           r_cnt;
  logic [1:0]           w_cnt_nxt;
  logic [CNT_W-1:0]     r_stall_cycles;
  logic                 w_unused;

  hazard_match #(.REG_AW(REG_AW)) u_match1 (
    .i_rs    (id_rs1),
    .i_use   (id_use1),
    .i_wen   (st_wen[N_HAZ_STG-1:0]),
    .i_rd    (st_rd[N_HAZ_STG*REG_AW-1:0]),
    .o_match (w_m1)
  );

  hazard_match #(.REG_AW(REG_AW)) u_match2 (
    .i_rs    (id_rs2),
    .i_use   (id_use2),
    .i_wen   (st_wen[N_HAZ_STG-1:0]),
    .i_rd    (st_rd[N_HAZ_STG*REG_AW-1:0]),
    .o_match (w_m2)
  );

  // The retired stage and (without bypassing) the load flags never affect the result
  assign w_unused = &{1'b0, st_wen[STG_RET], st_load, st_rd[4*REG_AW-1:3*REG_AW]};

`ifdef CTRL_HAZARD_FWD_EN
  // Only a load still in EX cannot be bypassed; it costs exactly one bubble
  assign w_hazard_cond = (w_m1[STG_EX] | w_m2[STG_EX]) & st_load[STG_EX];
  assign w_extra       = 2'd0;
`else
  // Any in-flight producer blocks decode; the youngest one sets the stall length
  assign w_hazard_cond = (|w_m1) | (|w_m2);
  assign w_extra       = extra_cycles(w_m1 | w_m2);
`endif

  assign w_hazard_now = id_valid & ~flush & w_hazard_cond;

  // FSM state and remaining-cycle register; reset drops any stall in progress at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: flush aborts, RUN arms a multi-cycle stall, STALL counts down
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 2'd0;
    end else if (r_state == ST_RUN) begin
      if (w_hazard_now && (w_extra != 2'd0)) begin
        w_state_nxt = ST_STALL;
        w_cnt_nxt   = w_extra;
      end
    end else begin
      if (r_cnt <= 2'd1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 2'd0;
      end else begin
        w_cnt_nxt   = r_cnt - 2'd1;
      end
    end
  end

  // Outputs: stall from the live hazard or the FSM, suppressed by flush; bypass selects
  always_comb begin
    stall = 1'b0;
    fwd1  = FWD_RF;
    fwd2  = FWD_RF;
    if (!flush) begin
      stall = w_hazard_now | (r_state == ST_STALL);
    end
`ifdef CTRL_HAZARD_FWD_EN
    fwd1 = youngest_fwd(w_m1);
    fwd2 = youngest_fwd(w_m2);
`endif
  end

  // Saturating count of cycles in which decode was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/ctrl_hazard.md
CTRL_HAZARD -- requirements
Module: ctrl_hazard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-statistics counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port id_valid  input  1  decode-stage instruction valid.
REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_AW each  decode source addresses.
REQ-007 SHALL have ports id_use1, id_use2  input  1 each  source actually read.
REQ-008 SHALL have port st_wen  input  4  per-stage register-write enable; bit0=EX, bit1=MEM, bit2=WB, bit3=retired.
REQ-009 SHALL have port st_load  input  4  per-stage load flag, same bit order.
REQ-010 SHALL have port st_rd  input  4*REG_AW  per-stage destination address; slice i belongs to stage i.
REQ-011 SHALL have port flush  input  1  pipeline flush.
REQ-012 SHALL have port stall  output  1  hold PC/ID and inject bubble into EX.
REQ-013 SHALL have ports fwd1, fwd2  output  2 each  operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-014 SHALL have port stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 SHALL define match(s,i) = st_wen[i] & id_use_s & (st_rd slice i == id_rs_s) & (id_rs_s != 0), for i in 0..2; stage 3 is never a hazard.
REQ-016 SHALL compute stall, fwd1 and fwd2 combinationally from the inputs and registered state, with zero-cycle latency.
REQ-017 SHALL drive hazard_now = id_valid & ~flush & (hazard condition of REQ-025 or REQ-026).
REQ-018 SHALL drive stall = hazard_now | (state == STALL).
REQ-019 SHALL implement FSM states RUN and STALL, with a 2-bit remaining-cycles counter cnt.
REQ-020 SHALL transition RUN -> STALL when hazard_now is true and the required extra cycles are greater than 0, loading cnt with that value.
REQ-021 SHALL, in STALL, decrement cnt every cycle and return to RUN after the cycle in which cnt == 1.
REQ-022 SHALL give flush priority over everything: the next state is RUN, cnt is cleared, and stall is 0 in the same cycle.
REQ-023 SHALL increment stall_cycles in every cycle where stall == 1, saturating at all-ones with no wrap.
REQ-024 SHALL resolve matches in several stages by letting the youngest (lowest index) win for forwarding and for stall length.

Configuration
REQ-025 SHALL, with macro CTRL_HAZARD_FWD_EN defined:
- fwd_s = lowest i with match(s,i), plus 1; 0 if no match.
- Hazard = match(s,0) & st_load[0] for either source (load-use).
- Stall lasts exactly 1 cycle; extra cycles = 0, so the FSM stays in RUN.
- While stall is asserted, fwd outputs are don't-care.
REQ-026 SHALL, without CTRL_HAZARD_FWD_EN:
- fwd1 = fwd2 = 0 always.
- Hazard = any match(s,i) for i in 0..2.
- Total stall = 3 - k cycles, where k is the youngest matching index; extra cycles = 2 - k.
- The register file is write-before-read in WB.

Reset
REQ-027 SHALL, on rst, asynchronously set state = RUN, cnt = 0 and stall_cycles = 0; stall then follows hazard_now only.
REQ-028 SHALL, when rst is asserted mid-stall, deassert the FSM contribution to stall immediately.

Structure
REQ-029 SHALL take from the shared package: stage index constants (EX=0, MEM=1, WB=2, RET=3), fwd encodings, FSM state enum and REG_AW default.
REQ-030 SHALL contain one natural sub-module, hazard_match: per-source comparison of one address against the 3 stages, returning a match vector.

Verification
REQ-031 SHALL cover: FWD_EN, st_wen=0001, st_load=0001, st_rd[0]=5, id_rs1=5, id_use1=1 -> stall=1 for 1 cycle; next cycle, with the load in MEM, fwd1=2.
REQ-032 SHALL cover: FWD_EN, ALU write in EX rd=7 and MEM rd=7, id_rs2=7 -> stall=0, fwd2=1 (youngest wins).
REQ-033 SHALL cover: no FWD, EX writes rd=3 and id_rs1=3 -> stall high 3 cycles, stall_cycles +3, then 0.
REQ-034 SHALL cover: id_rs1=0 with any stage writing rd=0 -> stall=0, fwd1=0.
REQ-035 SHALL cover: no FWD, flush asserted in the 2nd stall cycle -> stall=0 in that same cycle, state RUN the next cycle.
REQ-036 SHALL cover: stall_cycles preloaded near all-ones plus continued stall -> value holds at all-ones; rst mid-stall -> counter 0 and state RUN asynchronously.
